// File: rtl/aes_iter_core_if.sv
// Handshake and data bundle for aes_iter_core.
//   start/plaintext/key   : request side, driven by the block feeding the core
//   ready/busy/done       : core status; done is a one-cycle result strobe
//   ciphertext            : result, held until the next completed block
interface aes_iter_core_if #(
  parameter int unsigned NK = 4
);
  logic              start;
  logic [127:0]      plaintext;
  logic [32*NK-1:0]  key;
  logic              ready;
  logic              busy;
  logic              done;
  logic [127:0]      ciphertext;

  modport master (output start, plaintext, key,
                  input  ready, busy, done, ciphertext);
  modport slave  (input  start, plaintext, key,
                  output ready, busy, done, ciphertext);
endinterface

// File: rtl/aes_iter_core.sv
// Iterative AES encryption core (AES-128 when NK=4, AES-256 when NK=8).
// One block is encrypted in place on a 128-bit state register; SubBytes is
// spread over 16/SBOX_LANES cycles per round, followed by one cycle of
// ShiftRows/MixColumns/AddRoundKey. The key schedule runs alongside in a
// sliding NK-word window.
//   clk   : rising-edge clock
//   reset : asynchronous, active-low
//   bus   : start/plaintext/key in; ready/busy/done/ciphertext out
module aes_iter_core #(
  parameter int unsigned NK         = 4,
  parameter int unsigned SBOX_LANES = 16
) (
  input logic            clk,
  input logic            reset,
  aes_iter_core_if.slave bus
);
  localparam int unsigned NR      = NK + 6;
  localparam int unsigned SUB_CYC = 16 / SBOX_LANES;
  localparam int unsigned LANE_W  = (SUB_CYC > 1) ? $clog2(SUB_CYC) : 1;

  if (!(NK == 4 || NK == 8)) begin : g_bad_nk
    $error("aes_iter_core: NK must be 4 or 8");
  end
  if (!(SBOX_LANES == 4 || SBOX_LANES == 8 || SBOX_LANES == 16)) begin : g_bad_lanes
    $error("aes_iter_core: SBOX_LANES must be 4, 8 or 16");
  end

  localparam logic [0:2047] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[{b, 3'b000} +: 8];
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [7:0] xt(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] idx);
    case (idx)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  // Byte s(row,col) lives at byte index 4*col+row, byte 0 at the MSBs.
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] r;
    r = '0;
    for (int unsigned c = 0; c < 4; c++)
      for (int unsigned row = 0; row < 4; row++)
        r[127-8*(4*c+row) -: 8] = s[127-8*(4*((c+row)%4)+row) -: 8];
    return r;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] r;
    logic [7:0]   a0, a1, a2, a3;
    r = '0;
    for (int unsigned c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      r[127-32*c -: 8] = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
      r[119-32*c -: 8] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
      r[111-32*c -: 8] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
      r[103-32*c -: 8] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
    end
    return r;
  endfunction

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SUB, S_MIX, S_DONE} fsm_t;

  fsm_t              fsm_q, fsm_d;
  logic [127:0]      state_q, state_d;
  logic [32*NK-1:0]  win_q, win_d;
  logic [3:0]        round_q, round_d;
  logic [LANE_W-1:0] lane_q, lane_d;
  logic [127:0]      ct_q, ct_d;

  // Key schedule: produce the next four words from the window.
  logic [31:0]      last_w, temp, nw0, nw1, nw2, nw3;
  logic [3:0]       rcon_idx;
  logic             use_rot;
  logic [127:0]     new_words;
  logic [32*NK-1:0] win_next;

  // For NK=8 the first new word of round r has index 4r+4: a multiple of 8
  // (RotWord+Rcon) on odd rounds, 8k+4 (plain SubWord) on even rounds.
  always_comb begin
    last_w   = win_q[31:0];
    rcon_idx = (NK == 4) ? round_q : 4'((round_q + 4'd1) >> 1);
    use_rot  = (NK == 4) || round_q[0];
    if (use_rot) temp = sub_word({last_w[23:0], last_w[31:24]}) ^ {rcon(rcon_idx), 24'h0};
    else         temp = sub_word(last_w);
    nw0 = win_q[32*NK-1  -: 32] ^ temp;
    nw1 = win_q[32*NK-33 -: 32] ^ nw0;
    nw2 = win_q[32*NK-65 -: 32] ^ nw1;
    nw3 = win_q[32*NK-97 -: 32] ^ nw2;
    new_words = {nw0, nw1, nw2, nw3};
  end

  if (NK == 4) begin : g_win4
    assign win_next = new_words;
  end else begin : g_win8
    assign win_next = {win_q[127:0], new_words};
  end

  // Round key is always the oldest four words once the window has advanced.
  logic [127:0] sr, mc, rk, mix_res;
  always_comb begin
    sr      = shift_rows(state_q);
    mc      = mix_columns(sr);
    rk      = win_q[32*NK-1 -: 128];
    mix_res = ((round_q == 4'(NR)) ? sr : mc) ^ rk;
  end

  // Inputs are captured on the accept edge so LOAD never sees later changes.
  int unsigned b;
  always_comb begin
    fsm_d   = fsm_q;
    state_d = state_q;
    win_d   = win_q;
    round_d = round_q;
    lane_d  = lane_q;
    ct_d    = ct_q;
    b       = 0;
    case (fsm_q)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          fsm_d   = S_LOAD;
          state_d = bus.plaintext ^ bus.key[32*NK-1 -: 128];
          win_d   = bus.key;
          round_d = 4'd1;
          lane_d  = '0;
        end else begin
          fsm_d = S_IDLE;
        end
      end
      S_LOAD: fsm_d = S_SUB;
      S_SUB: begin
        for (int unsigned k = 0; k < SBOX_LANES; k++) begin
          b = 32'(lane_q) * SBOX_LANES + k;
          state_d[127-8*b -: 8] = sbox(state_q[127-8*b -: 8]);
        end
        if (lane_q == LANE_W'(SUB_CYC - 1)) begin
          win_d  = win_next;
          lane_d = '0;
          fsm_d  = S_MIX;
        end else begin
          lane_d = lane_q + LANE_W'(1);
        end
      end
      S_MIX: begin
        state_d = mix_res;
        if (round_q == 4'(NR)) begin
          ct_d  = mix_res;
          fsm_d = S_DONE;
        end else begin
          round_d = round_q + 4'd1;
          fsm_d   = S_SUB;
        end
      end
      default: fsm_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fsm_q   <= S_IDLE;
      state_q <= '0;
      win_q   <= '0;
      round_q <= '0;
      lane_q  <= '0;
      ct_q    <= '0;
    end else begin
      fsm_q   <= fsm_d;
      state_q <= state_d;
      win_q   <= win_d;
      round_q <= round_d;
      lane_q  <= lane_d;
      ct_q    <= ct_d;
    end
  end

  assign bus.ready      = (fsm_q == S_IDLE) || (fsm_q == S_DONE);
  assign bus.busy       = (fsm_q == S_LOAD) || (fsm_q == S_SUB) || (fsm_q == S_MIX);
  assign bus.done       = (fsm_q == S_DONE);
  assign bus.ciphertext = ct_q;
endmodule

// File: tb/tb_aes_iter_core.sv
// Bench for aes_iter_core: three configurations (NK4/L16, NK4/L4, NK8/L8)
// driven from a FIPS-197 vector table, plus back-to-back, busy-ignore and
// mid-operation reset sequences on the NK4/L16 instance.
module tb_aes_iter_core;
  logic clk;
  logic reset;

  logic         start_v [3];
  logic [127:0] pt_v    [3];
  logic [255:0] key_v   [3];
  logic         ready_v [3];
  logic         busy_v  [3];
  logic         done_v  [3];
  logic [127:0] ct_v    [3];

  aes_iter_core_if #(.NK(4)) if0 ();
  aes_iter_core_if #(.NK(4)) if1 ();
  aes_iter_core_if #(.NK(8)) if2 ();

  aes_iter_core #(.NK(4), .SBOX_LANES(16)) u0 (.clk(clk), .reset(reset), .bus(if0.slave));
  aes_iter_core #(.NK(4), .SBOX_LANES(4))  u1 (.clk(clk), .reset(reset), .bus(if1.slave));
  aes_iter_core #(.NK(8), .SBOX_LANES(8))  u2 (.clk(clk), .reset(reset), .bus(if2.slave));

  assign if0.start = start_v[0]; assign if0.plaintext = pt_v[0]; assign if0.key = key_v[0][255:128];
  assign if1.start = start_v[1]; assign if1.plaintext = pt_v[1]; assign if1.key = key_v[1][255:128];
  assign if2.start = start_v[2]; assign if2.plaintext = pt_v[2]; assign if2.key = key_v[2];
  assign ready_v[0] = if0.ready; assign busy_v[0] = if0.busy; assign done_v[0] = if0.done; assign ct_v[0] = if0.ciphertext;
  assign ready_v[1] = if1.ready; assign busy_v[1] = if1.busy; assign done_v[1] = if1.done; assign ct_v[1] = if1.ciphertext;
  assign ready_v[2] = if2.ready; assign busy_v[2] = if2.busy; assign done_v[2] = if2.done; assign ct_v[2] = if2.ciphertext;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    int unsigned  dut;
    logic [127:0] pt;
    logic [255:0] key;
    logic [127:0] ct;
    int unsigned  lat;
  } vec_t;

  vec_t        vecs [4];
  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned cyc;
  bit          flag;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Wait (bounded) for done on instance d; cycles counted from the accept edge.
  task automatic wait_done(input int unsigned d, output int unsigned n, output bit busy_ok);
    n = 0;
    busy_ok = 1'b1;
    while (done_v[d] !== 1'b1 && n < 200) begin
      if (busy_v[d] !== 1'b1 || ready_v[d] !== 1'b0) busy_ok = 1'b0;
      @(posedge clk); #1;
      n++;
    end
  endtask

  // One full encryption; with disturb set, junk inputs and a start pulse are
  // applied mid-run and must not affect the result.
  task automatic run_one(input int unsigned d, input logic [127:0] pt, input logic [255:0] key,
                         input logic [127:0] exp_ct, input int unsigned exp_lat,
                         input bit disturb, input string name);
    int unsigned n;
    bit          ok;
    @(negedge clk);
    check({name, " ready_before"}, 256'(ready_v[d]), 256'd1);
    pt_v[d] = pt; key_v[d] = key; start_v[d] = 1'b1;
    @(posedge clk); #1;
    start_v[d] = 1'b0;
    if (disturb) begin
      repeat (5) begin @(posedge clk); #1; end
      pt_v[d] = ~pt; key_v[d] = ~key; start_v[d] = 1'b1;
      repeat (2) begin @(posedge clk); #1; end
      start_v[d] = 1'b0;
      wait_done(d, n, ok);
      n = n + 7;
    end else begin
      wait_done(d, n, ok);
    end
    check({name, " latency"}, 256'(n), 256'(exp_lat));
    check({name, " ciphertext"}, 256'(ct_v[d]), 256'(exp_ct));
    check({name, " busy_during_run"}, 256'(ok), 256'd1);
    check({name, " ready_in_done"}, 256'(ready_v[d]), 256'd1);
    check({name, " busy_in_done"}, 256'(busy_v[d]), 256'd0);
    @(posedge clk); #1;
    check({name, " done_pulse_width"}, 256'(done_v[d]), 256'd0);
  endtask

  initial begin
    vecs[0] = '{0, 128'h3243f6a8885a308d313198a2e0370734,
                {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0},
                128'h3925841d02dc09fbdc118597196a0b32, 21};
    vecs[1] = '{1, 128'h00112233445566778899aabbccddeeff,
                {128'h000102030405060708090a0b0c0d0e0f, 128'h0},
                128'h69c4e0d86a7b0430d8cdb78070b4c55a, 51};
    vecs[2] = '{2, 128'h00112233445566778899aabbccddeeff,
                256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f,
                128'h8ea2b7ca516745bfeafc49904b496089, 43};
    vecs[3] = '{0, 128'h00112233445566778899aabbccddeeff,
                {128'h000102030405060708090a0b0c0d0e0f, 128'h0},
                128'h69c4e0d86a7b0430d8cdb78070b4c55a, 21};

    for (int i = 0; i < 3; i++) begin
      start_v[i] = 1'b0; pt_v[i] = '0; key_v[i] = '0;
    end
    reset = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("reset ready[%0d]", i), 256'(ready_v[i]), 256'd1);
      check($sformatf("reset busy[%0d]", i),  256'(busy_v[i]),  256'd0);
      check($sformatf("reset done[%0d]", i),  256'(done_v[i]),  256'd0);
      check($sformatf("reset ct[%0d]", i),    256'(ct_v[i]),    256'd0);
    end
    repeat (2) @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 4; i++)
      run_one(vecs[i].dut, vecs[i].pt, vecs[i].key, vecs[i].ct, vecs[i].lat, 1'b0,
              $sformatf("vec%0d", i));

    // Back-to-back: start held high, second block accepted in the DONE cycle.
    @(negedge clk);
    pt_v[0] = vecs[3].pt; key_v[0] = vecs[3].key; start_v[0] = 1'b1;
    @(posedge clk); #1;
    pt_v[0] = vecs[0].pt; key_v[0] = vecs[0].key;
    wait_done(0, cyc, flag);
    check("b2b first latency", 256'(cyc), 256'd21);
    check("b2b first ct", 256'(ct_v[0]), 256'(vecs[3].ct));
    @(posedge clk); #1;
    start_v[0] = 1'b0;
    check("b2b no_idle busy", 256'(busy_v[0]), 256'd1);
    check("b2b no_idle done", 256'(done_v[0]), 256'd0);
    wait_done(0, cyc, flag);
    check("b2b second latency", 256'(cyc), 256'd21);
    check("b2b second ct", 256'(ct_v[0]), 256'(vecs[0].ct));
    repeat (3) begin @(posedge clk); #1; end
    check("ct held after done", 256'(ct_v[0]), 256'(vecs[0].ct));
    check("ready after done", 256'(ready_v[0]), 256'd1);

    // Start and input changes while busy are ignored.
    run_one(0, vecs[3].pt, vecs[3].key, vecs[3].ct, 21, 1'b1, "busy_ignore");

    // Reset seven cycles into an encryption.
    @(negedge clk);
    pt_v[0] = vecs[0].pt; key_v[0] = vecs[0].key; start_v[0] = 1'b1;
    @(posedge clk); #1;
    start_v[0] = 1'b0;
    repeat (7) begin @(posedge clk); #1; end
    reset = 1'b0;
    #1;
    check("midreset ready", 256'(ready_v[0]), 256'd1);
    check("midreset busy",  256'(busy_v[0]),  256'd0);
    check("midreset done",  256'(done_v[0]),  256'd0);
    check("midreset ct",    256'(ct_v[0]),    256'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    flag = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (done_v[0] === 1'b1) flag = 1'b1;
    end
    check("midreset no_done", 256'(flag), 256'd0);
    run_one(0, vecs[0].pt, vecs[0].key, vecs[0].ct, 21, 1'b0, "after_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/aes_iter_core.md
Name: aes_iter_core

Overview:
- Iterative AES encryption core. It accepts one plaintext block and key, runs all rounds in place on a 128-bit state register, and returns the ciphertext with a one-cycle done pulse.
- Generalises the existing single-round datapath (sub-bytes, shift-rows, mix-columns, add-round-key, key expansion) in two ways:
  - key length is a parameter (AES-128 or AES-256);
  - the number of S-box lanes is a parameter, trading area for latency.
- Sits between the SPI receive/transmit logic and the host-facing result register.

Parameters:
- NK, 4, key length in 32-bit words; legal values 4 (AES-128) and 8 (AES-256). NR = NK+6 rounds.
- SBOX_LANES, 16, bytes substituted per cycle; legal values 4, 8, 16. SUB_CYC = 16/SBOX_LANES.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  request to encrypt; sampled only while ready=1.
- plaintext  input  128  block to encrypt; byte 0 (s00) at [127:120], column-major.
- key  input  32*NK  cipher key; word w0 at the MSBs.
- ready  output  1  core can accept start.
- busy  output  1  encryption in progress.
- done  output  1  one-cycle pulse; ciphertext valid from this cycle.
- ciphertext  output  128  result; same byte order as plaintext.

Behaviour:
- Reset (reset=0, asynchronous):
  - state → IDLE; state register, key window, round counter and ciphertext all cleared to 0.
  - ready=1, busy=0, done=0.
  - Applies mid-operation too: the in-flight block is discarded with no done pulse.
- FSM states:
  - IDLE: ready=1. start=1 → LOAD.
  - LOAD (1 cycle): state ← plaintext ^ key[32*NK-1 -: 128]; key window ← key; round ← 1; lane index ← 0 → SUB.
  - SUB (SUB_CYC cycles): each cycle substitutes bytes [lane*L .. lane*L+L-1] of the state in place (L = SBOX_LANES). In the last SUB cycle the next 4 key words are generated and appended to the window → MIX.
  - MIX (1 cycle): state ← AddRoundKey(MixColumns(ShiftRows(state)), rk).
    - MixColumns is bypassed when round==NR.
    - rk = the 4 oldest-relevant window words for this round.
    - round < NR → round+1 → SUB.
    - round == NR → ciphertext ← result → DONE.
  - DONE (1 cycle): done=1, ready=1.
    - start=1 → LOAD, accepted the same cycle; ciphertext is held until the next DONE.
    - otherwise → IDLE.
- busy = 1 in LOAD, SUB, MIX; busy and ready are never both 1.
- start while busy=1: ignored, no queuing. Inputs are sampled only in the accept cycle; later changes to plaintext or key have no effect.
- Latency: start-accept edge to done = 1 + NR*(SUB_CYC+1) cycles.
  - NK=4, L=16: 21.
  - NK=4, L=4: 51.
  - NK=8, L=16: 29.
- Key schedule:
  - Window holds NK words. The word index i continues from NK upward.
  - New word: w[i] = w[i-NK] ^ temp.
  - i%NK==0: temp = SubWord(RotWord(w[i-1])) ^ Rcon[i/NK].
  - NK=8 and i%8==4: temp = SubWord(w[i-1]).
  - Otherwise: temp = w[i-1].
  - Rcon sequence: 01,02,04,08,10,20,40,80,1b,36 in the MSB byte.
  - Uses 4 dedicated S-box lookups, separate from the data lanes.
  - For NK=8, round 1 uses the original w4..w7.
- S-boxes are combinational lookups; all state changes are registered on clk.
- Illegal parameters (NK not 4/8, SBOX_LANES not 4/8/16) are rejected by an elaboration-time assertion.

Test Plan:
- NK=4, L=16: pt 3243f6a8885a308d313198a2e0370734, key 2b7e151628aed2a6abf7158809cf4f3c → ct 3925841d02dc09fbdc118597196a0b32; done exactly 21 cycles after accept; single-cycle pulse.
- NK=4, L=4: pt 00112233445566778899aabbccddeeff, key 000102…0f → ct 69c4e0d86a7b0430d8cdb78070b4c55a; done at 51 cycles.
- NK=8, L=8: same pt, key 000102…1f → ct 8ea2b7ca516745bfeafc49904b496089; done at 1+14*3=43 cycles.
- Back-to-back: start held high through DONE with the second block = pt from scenario 1 → second accept in the DONE cycle; both ciphertexts correct; no idle cycle between them.
- start pulsed and plaintext/key changed while busy → ignored; result matches the originally accepted block.
- reset asserted at cycle 7 of an encryption → ready=1, ciphertext=0, no done; a fresh start afterwards produces the correct result.
